// File: rtl/exec_stage.sv
// exec_stage: ALU execute stage feeding a register-file write port; iterative MUL built only when `EXEC_MUL_EN is defined
module exec_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dest,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              write,
  output logic [ADDR_W-1:0] wr_Addr,
  output logic [DATA_W-1:0] wr_Data,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  logic              xfer;
  logic              alu_wr;
  logic [SH_W-1:0]   amt;
  logic [DATA_W:0]   shl_ext;
  logic [DATA_W:0]   shr_ext;
  logic [DATA_W:0]   alu_ext;
  logic              wr_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              c_nx;
  assign xfer    = in_valid && in_ready;
  assign alu_wr  = xfer && op != OP_MUL;
  assign amt     = opB[SH_W-1:0];
  // the bit shifted out lands in the extra bit, so amount 0 yields carry 0 for free
  assign shl_ext = {1'b0, opA} << amt;
  assign shr_ext = {opA, 1'b0} >> amt;
  // single-cycle ALU: carry/borrow in the top bit, result below it
  always_comb
    alu_ext = op == OP_ADD ? {1'b0, opA} + {1'b0, opB} :
              op == OP_SUB ? {1'b0, opA} - {1'b0, opB} :
              op == OP_AND ? {1'b0, opA & opB} :
              op == OP_OR  ? {1'b0, opA | opB} :
              op == OP_XOR ? {1'b0, opA ^ opB} :
              op == OP_SHL ? shl_ext :
              op == OP_SHR ? {shr_ext[0], shr_ext[DATA_W:1]} : '0;
`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   mul_dest;
  logic [DATA_W-1:0]   mul_b;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_nx;
  logic [SH_W:0]       cnt;
  logic                mul_done;
  assign acc_nx   = acc + (mul_b[0] ? mul_a : '0);
  assign mul_done = state == MUL && cnt == (SH_W+1)'(1);
  assign illegal  = 1'b0;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: enter MUL on a multiply transfer, leave on the last iteration
  always_comb
    state_nx = state == IDLE ? ((xfer && op == OP_MUL) ? MUL : IDLE) :
               (mul_done ? IDLE : MUL);
  // handshake outputs depend on state only
  always_comb begin
    in_ready = state == IDLE;
    busy     = state == MUL;
  end
  // shift-and-add multiplier; A is pre-shifted so each step adds A << (16 - counter)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_dest <= '0;
    end else if (xfer && op == OP_MUL) begin
      mul_a    <= {{DATA_W{1'b0}}, opA};
      mul_b    <= opB;
      acc      <= '0;
      cnt      <= (SH_W+1)'(DATA_W);
      mul_dest <= dest;
    end else if (state == MUL) begin
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      acc   <= acc_nx;
      cnt   <= cnt - (SH_W+1)'(1);
    end
  // select the pending write source; MUL and ALU writes cannot coincide since in_ready is low in MUL
  always_comb begin
    wr_nx   = alu_wr || mul_done;
    addr_nx = mul_done ? mul_dest : dest;
    data_nx = mul_done ? acc_nx[DATA_W-1:0] : alu_ext[DATA_W-1:0];
    c_nx    = mul_done ? |acc_nx[2*DATA_W-1:DATA_W] : alu_ext[DATA_W];
  end
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
  // op 111 is rejected with a one-cycle pulse and no write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) illegal <= 1'b0;
    else illegal <= xfer && op == OP_MUL;
  // only single-cycle ALU results are ever written
  always_comb begin
    wr_nx   = alu_wr;
    addr_nx = dest;
    data_nx = alu_ext[DATA_W-1:0];
    c_nx    = alu_ext[DATA_W];
  end
`endif
  // write pulse plus result and flags; result and flags hold between writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      write   <= 1'b0;
      wr_Addr <= '0;
      wr_Data <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      write <= wr_nx;
      if (wr_nx) begin
        wr_Addr <= addr_nx;
        wr_Data <= data_nx;
        flag_z  <= data_nx == '0;
        flag_c  <= c_nx;
      end
    end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vector bench for exec_stage, covering either build of the multiplier
module tb_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [2:0]  dest = 3'd0;
  logic [15:0] opA = 16'd0;
  logic [15:0] opB = 16'd0;
  logic        write;
  logic [2:0]  wr_Addr;
  logic [15:0] wr_Data;
  logic        busy;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic [2:0]  op;
    logic [2:0]  dest;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        z;
    logic        c;
  } vec_t;
  localparam int NV = 16;
  vec_t vecs[NV];
  exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dest(dest), .opA(opA), .opB(opB),
    .write(write), .wr_Addr(wr_Addr), .wr_Data(wr_Data), .busy(busy),
    .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
`ifdef EXEC_MUL_EN
  task automatic mul_seq(input logic [15:0] a, input logic [15:0] b, input logic [2:0] d,
                         input logic [15:0] ed, input logic ez, input logic ec, input string nm);
    int n = 0;
    logic wr_seen = 1'b0;
    op = 3'd7; opA = a; opB = b; dest = d; in_valid = 1'b1;
    step;
    chk({nm, "_start"}, {in_ready, busy, write, illegal}, 4'b0100);
    opA = 16'hFFFF; opB = 16'hFFFF;
    while (!in_ready && n < 40) begin
      n++;
      wr_seen |= write;
      step;
    end
    chk({nm, "_stall"}, n, 16);
    chk({nm, "_nowr"}, wr_seen, 1'b0);
    chk({nm, "_res"}, {write, wr_Addr, wr_Data, flag_z, flag_c, busy, illegal},
        {1'b1, d, ed, ez, ec, 1'b0, 1'b0});
    op = 3'd0; opA = 16'd1; opB = 16'd1; dest = 3'd3;
    step;
    chk({nm, "_next"}, {write, wr_Addr, wr_Data, flag_z, flag_c}, {1'b1, 3'd3, 16'h0002, 1'b0, 1'b0});
    in_valid = 1'b0;
    step;
  endtask
`endif
  initial begin
    vecs[0]  = '{3'd0, 3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{3'd1, 3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1};
    vecs[2]  = '{3'd4, 3'd3, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
    vecs[3]  = '{3'd5, 3'd0, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1};
    vecs[4]  = '{3'd6, 3'd1, 16'h0003, 16'h0000, 16'h0003, 1'b0, 1'b0};
    vecs[5]  = '{3'd2, 3'd5, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 3'd7, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0};
    vecs[7]  = '{3'd1, 3'd4, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{3'd0, 3'd6, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 3'd2, 16'hC000, 16'h000F, 16'h0001, 1'b0, 1'b1};
    vecs[10] = '{3'd5, 3'd3, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0};
    vecs[11] = '{3'd5, 3'd1, 16'h4000, 16'h0002, 16'h0000, 1'b1, 1'b1};
    vecs[12] = '{3'd6, 3'd0, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{3'd5, 3'd2, 16'hFFFF, 16'h0010, 16'hFFFF, 1'b0, 1'b0};
    vecs[14] = '{3'd2, 3'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{3'd0, 3'd5, 16'h8000, 16'h8001, 16'h0001, 1'b0, 1'b1};
    #2;
    step;
    step;
    chk("reset", {write, wr_Addr, wr_Data, flag_z, flag_c, illegal, busy, in_ready},
        {1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    step;
    in_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      op = vecs[i].op; dest = vecs[i].dest; opA = vecs[i].a; opB = vecs[i].b;
      step;
      chk($sformatf("vec%0d", i), {write, wr_Addr, wr_Data, flag_z, flag_c, illegal},
          {1'b1, vecs[i].dest, vecs[i].data, vecs[i].z, vecs[i].c, 1'b0});
    end
    in_valid = 1'b0;
    step;
    chk("hold", {write, wr_Addr, wr_Data, flag_z, flag_c},
        {1'b0, vecs[NV-1].dest, vecs[NV-1].data, vecs[NV-1].z, vecs[NV-1].c});
`ifdef EXEC_MUL_EN
    mul_seq(16'h0100, 16'h0101, 3'd0, 16'h0100, 1'b0, 1'b1, "mul_a");
    mul_seq(16'hFFFF, 16'hFFFF, 3'd6, 16'h0001, 1'b0, 1'b1, "mul_b");
    mul_seq(16'h0000, 16'h1234, 3'd2, 16'h0000, 1'b1, 1'b0, "mul_c");
    mul_seq(16'h0003, 16'h0005, 3'd1, 16'h000F, 1'b0, 1'b0, "mul_d");
    op = 3'd7; opA = 16'h00FF; opB = 16'h00FF; dest = 3'd4; in_valid = 1'b1;
    step;
    repeat (8) step;
    chk("mid_busy", {busy, in_ready}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {write, wr_Addr, wr_Data, flag_z, flag_c, illegal, busy, in_ready},
        {1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    in_valid = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    begin
      logic wr_seen = 1'b0;
      repeat (20) begin
        step;
        wr_seen |= write;
      end
      chk("post_rst", {wr_seen, busy, in_ready, wr_Data}, {1'b0, 1'b0, 1'b1, 16'd0});
    end
`else
    op = 3'd0; opA = 16'd1; opB = 16'd1; dest = 3'd3; in_valid = 1'b1;
    step;
    chk("pre_add", {write, wr_Addr, wr_Data, flag_z, flag_c}, {1'b1, 3'd3, 16'h0002, 1'b0, 1'b0});
    op = 3'd7; opA = 16'd5; opB = 16'd6; dest = 3'd4;
    step;
    chk("illegal", {illegal, write, wr_Addr, wr_Data, flag_z, flag_c, busy, in_ready},
        {1'b1, 1'b0, 3'd3, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1});
    op = 3'd0; opA = 16'h7FFF; opB = 16'h0001; dest = 3'd5;
    step;
    chk("after_ill", {illegal, write, wr_Addr, wr_Data, flag_z, flag_c},
        {1'b0, 1'b1, 3'd5, 16'h8000, 1'b0, 1'b0});
    op = 3'd7; opA = 16'd0; opB = 16'd0;
    step;
    chk("illegal2", {illegal, write, wr_Data, flag_z, flag_c}, {1'b1, 1'b0, 16'h8000, 1'b0, 1'b0});
    in_valid = 1'b0;
    step;
    chk("ill_clear", {illegal, write}, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {write, wr_Addr, wr_Data, flag_z, flag_c, illegal, busy, in_ready},
        {1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    step;
    rst_n = 1'b1;
    step;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage that sits directly upstream of the 4×16-bit register file's write port and downstream of its two read ports. Accepts an operation with operands A and B (driven from `rd_DataA`/`rd_DataB`) and a destination address through a valid/ready handshake. Single-cycle ALU ops complete at one per clock; an optional iterative 16×16 multiply takes 16 cycles. The result is emitted as a one-cycle `write`/`wr_Addr`/`wr_Data` pulse that connects directly to the register file.

## Interface
- `DATA_W`, 16, operand/result width
- `ADDR_W`, 3, register address width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  op/operands/dest valid this cycle
- `in_ready`  out  1  stage can accept; a transfer occurs on an edge where `in_valid && in_ready`
- `op`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- `dest`  in  ADDR_W  destination register
- `opA`  in  DATA_W  operand A
- `opB`  in  DATA_W  operand B
- `write`  out  1  one-cycle write strobe to the register file
- `wr_Addr`  out  ADDR_W  write address
- `wr_Data`  out  DATA_W  write data
- `busy`  out  1  multiply in progress
- `flag_z`  out  1  last written result == 0
- `flag_c`  out  1  carry/borrow/overflow of last written result
- `illegal`  out  1  one-cycle pulse for a rejected op

## Operation
- States: IDLE, MUL.
- **IDLE:**
  - `in_ready`=1, `busy`=0.
  - On transfer of ops 000–110: the result, `dest` and flags are registered, and `write`=1 for the next cycle only. State stays IDLE, so back-to-back ops complete one per cycle.
- **MUL transfer:**
  - Latch A, B and `dest`; clear the 32-bit accumulator; set counter=16; go to MUL.
  - `in_ready`=0 and `busy`=1 while in MUL.
- **MUL iteration:**
  - Each edge: if B[0], add A shifted by (16−counter) to the accumulator; shift B right; decrement counter.
  - On the edge where counter goes 1→0: `wr_Data`=acc[15:0], `write`=1 for that following cycle, return to IDLE.
- **Arithmetic:**
  - ADD: c = bit 16 of the 17-bit sum.
  - SUB: A−B mod 2^16; c=1 iff A<B unsigned (borrow).
  - AND/OR/XOR: c=0.
  - SHL/SHR: amount = opB[3:0]; amount 0 gives c=0. Otherwise SHL c = A[16−amt], SHR c = A[amt−1] (logical, zero fill).
  - MUL: c=1 iff acc[31:16]≠0.
- Flags update only on cycles where `write` is asserted, and hold otherwise.
- `dest` 4–7 is passed through unchanged with `write` asserted; the register file drops the write.
- `write` is 0 in every cycle not explicitly listed above. `wr_Addr`/`wr_Data` hold their last value when `write`=0.

## Timing
- Reset values: `write`=0, `wr_Addr`=0, `wr_Data`=0, `flag_z`=0, `flag_c`=0, `illegal`=0, `busy`=0. State=IDLE, so `in_ready`=1 after reset.
- Single-cycle ops: transfer at edge E0 gives `write`=1 between E0 and E1 (latency 1).
- MUL: transfer at E0, iterations at E1..E16, `write`=1 between E16 and E17.
  - `in_ready` returns to 1 in the E16–E17 cycle, so a new op can transfer at E17.
  - The writes of the MUL and of the following op never overlap.
- `in_valid` while `in_ready`=0 is ignored; upstream holds the request.
- Reset asserted mid-MUL aborts immediately. No write is issued; all outputs go to reset values.
- Operands are sampled only at transfer. Changes to `opA`/`opB` after transfer, including register-file updates from this stage's own write, do not affect an in-flight MUL.
- `in_ready` is a function of state only, with no combinational path from `in_valid`.

## Configuration
- `EXEC_MUL_EN` defined: MUL is implemented as described.
- `EXEC_MUL_EN` undefined:
  - MUL state and accumulator are not synthesized; `busy` is tied to 0.
  - A transfer with op 111 completes as a single-cycle op: no `write`, flags unchanged, `illegal`=1 for the next cycle.
  - With the macro defined, `illegal` is constant 0.

## Test plan
- Reset, then ADD A=0xFFFF B=0x0001 dest=2 → next cycle `write`=1, `wr_Addr`=2, `wr_Data`=0x0000, `flag_z`=1, `flag_c`=1.
- Back-to-back SUB 5−7 (dest 1) then XOR 0xAAAA^0x5555 (dest 3) on consecutive edges → consecutive writes 0xFFFE (c=1), then 0xFFFF (z=0, c=0).
- SHL A=0x8001 B=0x0001 → 0x0002, c=1. SHR A=0x0003 B=0x0000 → 0x0003, c=0.
- MUL 0x0100×0x0101 dest=0 with `in_valid` held high throughout:
  - `in_ready`=0 for exactly 16 cycles.
  - `write`=1 on cycle 16 after transfer with `wr_Data`=0x0100, c=1 (product 0x10100).
  - Next op transfers at E17.
- `rst_n` pulsed low 8 cycles into a MUL → no `write`, all outputs at reset values, `in_ready`=1 after release.
- Build without `EXEC_MUL_EN`, issue op 111 → `illegal` pulses one cycle, `write` stays 0, flags unchanged.
